// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int N_REQ_DEFAULT     = 4;
   localparam int DATA_W_DEFAULT    = 8;
   localparam int BURST_MAX_DEFAULT = 4;

   // Bits needed to encode values 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) width++;
      return width;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT
) (
   input  logic [N_REQ-1:0]        req,
   input  logic [clog2(N_REQ)-1:0] last,
   output logic [clog2(N_REQ)-1:0] pick,
   output logic                    any
);

   localparam int ID_W = clog2(N_REQ);

   int idx;

   // Scan from the farthest offset down so the nearest request overwrites the rest.
   always_comb begin
      // NOTE: defaults first so every path assigns pick/idx and no latch is inferred.
      pick = '0;
      idx  = 0;
      for (int offset = N_REQ; offset >= 1; offset--) begin
         idx = (int'(last) + offset) % N_REQ;
         if (req[idx[ID_W-1:0]]) pick = idx[ID_W-1:0];
      end
   end

   assign any = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side arbiter: grants one producer at a time a bounded burst into a shared FIFO.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEFAULT,
   parameter int DATA_W    = DATA_W_DEFAULT,
   parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_write_en,
   output logic [DATA_W-1:0]         fifo_data_in,
   output logic [clog2(N_REQ)-1:0]   grant_id,
   output logic                      busy
);

   localparam int ID_W  = clog2(N_REQ);
   localparam int CNT_W = clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

   arb_state_t       state;
   logic [ID_W-1:0]  owner;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  pick_idx;
   logic [CNT_W-1:0] burst_cnt;
   logic             pick_any;
   logic             owner_valid;
   logic             write_now;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req  (req_valid),
      .last (last_grant),
      .pick (pick_idx),
      .any  (pick_any)
   );

   // fifo_full is used in the same cycle so a write can never land on a full FIFO.
   assign owner_valid   = req_valid[owner];
   assign write_now     = (state == BURST) && owner_valid && !fifo_full;
   assign fifo_write_en = write_now;
   assign fifo_data_in  = req_data[int'(owner)*DATA_W +: DATA_W];

   always_comb begin
      req_ready        = '0;
      req_ready[owner] = write_now;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         state      <= IDLE;
         owner      <= '0;
         grant_id   <= '0;
         last_grant <= ID_LAST;
         burst_cnt  <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state     <= BURST;
                  owner     <= pick_idx;
                  grant_id  <= pick_idx;
                  burst_cnt <= '0;
                  busy      <= 1'b1;
               end
            end
            BURST: begin
               // Leaving clears the count so it never holds BURST_MAX.
               if (!owner_valid || (write_now && burst_cnt == CNT_LAST)) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  last_grant <= owner;
                  burst_cnt  <= '0;
               end else if (write_now) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a transaction-level arbiter model.
module tb_fifo_write_arbiter;

   localparam int N     = 4;
   localparam int DW    = 8;
   localparam int BM    = 4;
   localparam int DEPTH = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic            fifo_full = 1'b0;
   logic            fifo_write_en;
   logic [DW-1:0]   fifo_data_in;
   logic [1:0]      grant_id;
   logic            busy;

   always #5 clk = ~clk;

   fifo_write_arbiter dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fifo_full     (fifo_full),
      .fifo_write_en (fifo_write_en),
      .fifo_data_in  (fifo_data_in),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] pq [N][$];
   bit         present [N];
   bit         rand_mode = 1'b0;
   logic [7:0] fq [$];
   logic [7:0] eq [$];

   int dut_grants [$];
   int grant_cyc [$];
   int gw [$];
   int cyc = 0;
   int first_we_cyc = -1;
   bit prev_busy = 1'b0;
   int wr_when_full = 0;

   bit m_busy = 1'b0;
   int m_owner = 0;
   int m_cnt = 0;
   int m_last = N - 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_next(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic int at(input int q [$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic clear_logs();
      dut_grants.delete();
      grant_cyc.delete();
      gw.delete();
      first_we_cyc = -1;
      cyc = 0;
   endtask

   task automatic clear_producers();
      for (int i = 0; i < N; i++) begin
         pq[i].delete();
         present[i] = 1'b1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      check("rst_busy",  32'(busy), 0);
      check("rst_we",    32'(fifo_write_en), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_grant", 32'(grant_id), 0);
      m_busy = 1'b0;
      m_owner = 0;
      m_cnt = 0;
      m_last = N - 1;
      fq.delete();
      eq.delete();
      prev_busy = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic cycle(input bit rd);
      logic [N-1:0] v;
      logic [N-1:0] exp_ready;
      bit           exp_w;
      logic         dut_we;
      logic [7:0]   dut_d;
      logic [7:0]   a;
      logic [7:0]   b;
      int           p;
      for (int i = 0; i < N; i++) begin
         if (rand_mode) begin
            if (pq[i].size() == 0 && $urandom_range(0, 5) == 0) begin
               for (int k = 0; k < int'($urandom_range(1, 6)); k++) pq[i].push_back(8'($urandom));
            end
            if (!present[i]) present[i] = ($urandom_range(0, 2) == 0);
         end
         v[i] = present[i] && (pq[i].size() > 0);
         req_data[i*DW +: DW] = v[i] ? pq[i][0] : 8'h00;
      end
      req_valid = v;
      fifo_full = (fq.size() >= DEPTH);

      @(negedge clk);
      exp_w = m_busy && v[m_owner] && !fifo_full;
      exp_ready = exp_w ? (N'(1) << m_owner) : '0;
      check("busy",  32'(busy), 32'(m_busy));
      check("grant", 32'(grant_id), m_busy ? m_owner : 32'(grant_id === 2'(m_owner) ? m_owner : m_owner));
      check("we",    32'(fifo_write_en), 32'(exp_w));
      check("ready", 32'(req_ready), 32'(exp_ready));
      if (exp_w) check("data", 32'(fifo_data_in), 32'(pq[m_owner][0]));

      if (busy && !prev_busy) begin
         dut_grants.push_back(int'(grant_id));
         grant_cyc.push_back(cyc);
         gw.push_back(0);
      end
      prev_busy = busy;
      if (fifo_write_en) begin
         if (gw.size() > 0) gw[gw.size()-1] = gw[gw.size()-1] + 1;
         if (first_we_cyc < 0) first_we_cyc = cyc;
         if (fifo_full) wr_when_full++;
      end
      dut_we = fifo_write_en;
      dut_d  = fifo_data_in;

      @(posedge clk);
      if (rd && fq.size() > 0 && eq.size() > 0) begin
         a = fq.pop_front();
         b = eq.pop_front();
         check("fifo_rd", 32'(a), 32'(b));
      end
      if (dut_we) fq.push_back(dut_d);

      if (!m_busy) begin
         p = rr_next(v, m_last);
         if (p >= 0) begin
            m_busy = 1'b1;
            m_owner = p;
            m_cnt = 0;
         end
      end else begin
         if (exp_w) begin
            eq.push_back(pq[m_owner][0]);
            void'(pq[m_owner].pop_front());
            m_cnt++;
            if (rand_mode) present[m_owner] = 1'($urandom_range(0, 1));
         end
         if (!v[m_owner] || m_cnt == BM) begin
            m_busy = 1'b0;
            m_last = m_owner;
         end
      end
      cyc++;
      #1;
   endtask

   initial begin
      logic [7:0] snap [$];
      clear_producers();
      #2;
      do_reset();

      // Single producer 0, three words, empty FIFO.
      clear_logs();
      pq[0] = '{8'hA1, 8'hA2, 8'hA3};
      for (int c = 0; c < 8; c++) cycle(1'b0);
      check("t1_first_write_cycle", first_we_cyc, 1);
      check("t1_grants", dut_grants.size(), 1);
      check("t1_writes", at(gw, 0), 3);
      check("t1_fifo_level", fq.size(), 3);
      snap = fq;
      check("t1_word0", (snap.size() > 0) ? 32'(snap[0]) : 32'hFFFF, 32'hA1);
      check("t1_word1", (snap.size() > 1) ? 32'(snap[1]) : 32'hFFFF, 32'hA2);
      check("t1_word2", (snap.size() > 2) ? 32'(snap[2]) : 32'hFFFF, 32'hA3);
      for (int c = 0; c < 4; c++) cycle(1'b1);

      // All producers valid continuously.
      do_reset();
      clear_producers();
      clear_logs();
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 8; k++) pq[i].push_back(8'((i << 4) | k));
      for (int c = 0; c < 26; c++) cycle(1'b1);
      check("t2_grant0", at(dut_grants, 0), 0);
      check("t2_grant1", at(dut_grants, 1), 1);
      check("t2_grant2", at(dut_grants, 2), 2);
      check("t2_grant3", at(dut_grants, 3), 3);
      check("t2_grant4", at(dut_grants, 4), 0);
      for (int g = 0; g < 4; g++) check("t2_burst_len", at(gw, g), BM);
      check("t2_grant_spacing", at(grant_cyc, 1) - at(grant_cyc, 0), BM + 1);

      // FIFO pre-filled to 7, producer 2 with three words, reads withheld.
      do_reset();
      clear_producers();
      clear_logs();
      for (int k = 0; k < 7; k++) begin
         fq.push_back(8'(8'h70 + k));
         eq.push_back(8'(8'h70 + k));
      end
      pq[2] = '{8'hC1, 8'hC2, 8'hC3};
      for (int c = 0; c < 6; c++) cycle(1'b0);
      check("t3_one_write", at(gw, 0), 1);
      check("t3_fifo_full_level", fq.size(), DEPTH);
      check("t3_grant_held", 32'(grant_id), 2);
      check("t3_busy_held", 32'(busy), 1);
      check("t3_no_rotation", dut_grants.size(), 1);
      cycle(1'b1);
      for (int c = 0; c < 3; c++) cycle(1'b0);
      check("t3_resume_write", at(gw, 0), 2);
      for (int c = 0; c < 16; c++) cycle(1'b1);

      // Producers 1 and 3 with last grant at 1.
      do_reset();
      clear_producers();
      clear_logs();
      pq[1] = '{8'h11};
      for (int c = 0; c < 4; c++) cycle(1'b1);
      clear_logs();
      pq[1] = '{8'h12, 8'h13};
      pq[3] = '{8'h31, 8'h32};
      for (int c = 0; c < 10; c++) cycle(1'b1);
      check("t4_first_pick", at(dut_grants, 0), 3);
      check("t4_second_pick", at(dut_grants, 1), 1);

      // Reset mid-burst on producer 2 after two writes.
      do_reset();
      clear_producers();
      clear_logs();
      pq[2] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
      for (int c = 0; c < 3; c++) cycle(1'b1);
      check("t5_writes_before_reset", at(gw, 0), 2);
      check("t5_busy_before_reset", 32'(busy), 1);
      pq[0] = '{8'h01, 8'h02};
      do_reset();
      clear_logs();
      for (int c = 0; c < 6; c++) cycle(1'b1);
      check("t5_first_after_reset", at(dut_grants, 0), 0);

      // Owner drops valid after one write while another waits.
      do_reset();
      clear_producers();
      clear_logs();
      pq[0] = '{8'h0A};
      pq[2] = '{8'h2A, 8'h2B, 8'h2C, 8'h2D, 8'h2E};
      for (int c = 0; c < 13; c++) cycle(1'b1);
      check("t6_grant0", at(dut_grants, 0), 0);
      check("t6_grant1", at(dut_grants, 1), 2);
      check("t6_grant2", at(dut_grants, 2), 2);
      check("t6_writes0", at(gw, 0), 1);
      check("t6_writes1", at(gw, 1), BM);
      check("t6_writes2", at(gw, 2), 1);

      // Random traffic with random FIFO reads.
      do_reset();
      clear_producers();
      clear_logs();
      rand_mode = 1'b1;
      for (int c = 0; c < 800; c++) cycle(1'($urandom_range(0, 1)));
      rand_mode = 1'b0;
      for (int i = 0; i < N; i++) present[i] = 1'b1;
      for (int c = 0; c < 80; c++) cycle(1'b1);
      check("rand_fifo_level", fq.size(), eq.size());
      check("no_write_when_full", wr_when_full, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-side arbiter that shares one 8-deep × 8-bit synchronous FIFO among N producers. Each producer offers data with a valid/ready handshake; the arbiter grants one producer at a time for a bounded burst and drives the FIFO's write_en/data_in. It never writes while the FIFO reports full. It sits directly in front of the FIFO's write port; the FIFO's read side is untouched.

## Interface
- N_REQ, 4, number of producers (2..8)
- DATA_W, 8, data width; matches FIFO data_in
- BURST_MAX, 4, max writes per grant before rotation (1..15)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- req_valid  in  N_REQ  producer i has a word on req_data slice i
- req_data  in  N_REQ*DATA_W  packed producer data; slice i = bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot or zero; word i accepted this cycle when valid&ready
- fifo_full  in  1  FIFO full flag (combinational from FIFO count)
- fifo_write_en  out  1  to FIFO write_en
- fifo_data_in  out  DATA_W  to FIFO data_in
- grant_id  out  clog2(N_REQ)  current owner index
- busy  out  1  high in state BURST

## Operation
- States: IDLE, BURST.
- IDLE: if any req_valid, pick the first valid index searching upward (mod N_REQ) from last_grant+1; register owner <= pick, burst_cnt <= 0, go BURST. Otherwise remain IDLE. No writes in IDLE.
- BURST: write condition w = req_valid[owner] & !fifo_full.
  - fifo_write_en = w; req_ready[owner] = w; all other req_ready = 0.
  - fifo_data_in = req_data slice owner (combinational mux, valid whenever in BURST).
  - On w: burst_cnt <= burst_cnt + 1.
  - Exit to IDLE, and set last_grant <= owner, when either condition holds:
    - w and burst_cnt == BURST_MAX-1;
    - !req_valid[owner].
- fifo_full with the owner valid: stall. The grant is held, burst_cnt is unchanged, and there is no rotation.
- burst_cnt width is clog2(BURST_MAX+1). It never exceeds BURST_MAX-1 while registered.
- Producers must hold valid/data stable until accepted. The arbiter does not check this.

## Timing
- Reset values:
  - state = IDLE, owner = 0, grant_id = 0, burst_cnt = 0.
  - last_grant = N_REQ-1, so producer 0 wins first.
  - All req_ready = 0, fifo_write_en = 0, busy = 0.
- Reset asserted mid-burst returns to IDLE immediately (async). A write in progress that cycle is dropped from the arbiter's view. The FIFO is reset by the same signal.
- Latency: valid asserted in an IDLE cycle leads to the first FIFO write in the next cycle. Each grant therefore costs one arbitration bubble.
- Peak throughput: BURST_MAX writes per BURST_MAX+1 cycles.
- fifo_full is sampled combinationally in the same cycle. fifo_write_en is never high while fifo_full is high, because the FIFO's count otherwise corrupts.
- Simultaneous FIFO read and arbiter write in the same cycle is legal. The FIFO handles it.
- grant_id reflects owner and changes only on the IDLE→BURST edge.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - default N_REQ, DATA_W, BURST_MAX constants;
  - a clog2 helper for grant_id and burst_cnt widths.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, last index.
  - Outputs: pick index, any.
- Top level holds the FSM, counters, data mux and ready decode.

## Test plan
- Single producer 0 with 3 words (0xA1, 0xA2, 0xA3), FIFO empty: grant after 1 bubble, 3 consecutive writes, exit on valid drop. FIFO reads back A1, A2, A3.
- All 4 producers valid continuously, BURST_MAX=4: grant order 0, 1, 2, 3, 0. Exactly 4 writes per grant, one idle cycle between grants.
- FIFO pre-filled to 7, producer 2 with 3 words, no reads:
  - one write, then fifo_full holds fifo_write_en = 0 and grant_id = 2;
  - after a single FIFO read, one more write resumes.
- Producers 1 and 3 valid, last_grant = 1: producer 3 wins. Next grant goes to producer 1.
- Reset pulsed low mid-burst on producer 2 after 2 writes:
  - outputs go to reset values immediately;
  - after release, producer 0 is granted first if valid.
- Owner drops valid after 1 write with others waiting: return to IDLE, then rotate to the next valid index. burst_cnt starts at 0 for the new owner.
